mem_copy_initiator: RTL

- Initiator-side master for the 8-bit single-port data_memory interface.
- Copies a block of LENGTH bytes from SRC to DST in data memory.
- Issues one read cycle, then one write cycle, per byte; two cycles per byte.
- Sits beside the datapath and takes over the memory port while busy; external muxing of the port is outside this block.

---
 rtl/mem_copy_pkg.sv | 19 +
 rtl/mem_copy_initiator_if.sv | 45 ++++
 rtl/mem_copy_initiator.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared constants and FSM state encoding for mem_copy_initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_copy_pkg;

  // Default widths. The length counter is one bit wider than the address so a
  // full 2^ADDR_W byte copy can be expressed.
  localparam int MC_ADDR_W = 8;
  localparam int MC_DATA_W = 8;
  localparam int MC_LEN_W  = MC_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_initiator_if.sv
// mem_copy_initiator_if: command inputs, status outputs and data_memory port of
// the copy initiator. master = initiator side, slave = datapath/memory side.
// Optional checksum signal present only when MEM_COPY_CHECKSUM_EN is defined.
interface mem_copy_initiator_if
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DATA_W = MC_DATA_W,
  parameter int LEN_W  = MC_LEN_W
);
  // Command
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  // Status
  logic              busy;
  logic              done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif
  // data_memory port
  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    input  start, src_addr, dst_addr, length, mem_read_data,
`ifdef MEM_COPY_CHECKSUM_EN
    output checksum,
`endif
    output busy, done, mem_access_addr, mem_write_data, mem_write_en, mem_read
  );

  modport slave (
    output start, src_addr, dst_addr, length, mem_read_data,
`ifdef MEM_COPY_CHECKSUM_EN
    input  checksum,
`endif
    input  busy, done, mem_access_addr, mem_write_data, mem_write_en, mem_read
  );

endinterface

// File: rtl/mem_copy_initiator.sv
// mem_copy_initiator: copies LENGTH bytes SRC->DST through an 8-bit single-port
//   data_memory, one READ cycle then one WRITE cycle per byte.
// Latency: start accepted at edge k -> done in cycle k+2N+1 (k+1 for N=0).
// Backpressure: none; start while busy is dropped, memory assumed zero-wait.
// Ports: clk, rst_n (sync, active-low); bus (mem_copy_initiator_if.master):
//   start/src_addr/dst_addr/length in, busy/done out, memory addr/wdata/we/rd
//   out, mem_read_data in (combinational).
// Option: MEM_COPY_CHECKSUM_EN adds bus.checksum, the modulo sum of bytes read.
module mem_copy_initiator
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DATA_W = MC_DATA_W,
  parameter int LEN_W  = MC_LEN_W
)(
  input  logic                 clk,
  input  logic                 rst_n,
  mem_copy_initiator_if.master bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_buf;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  logic              w_busy;
  logic              w_done;
  logic              w_mem_read;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and Moore outputs. Read and write strobes are tied to disjoint
  // states, so they can never be high together.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_we    = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          // A zero-length request completes without touching memory.
          w_state_nxt = (bus.length == '0) ? DONE : READ;
        end
      end
      READ: begin
        w_busy      = 1'b1;
        w_mem_read  = 1'b1;
        w_addr      = r_src_ptr;
        w_state_nxt = WRITE;
      end
      WRITE: begin
        w_busy      = 1'b1;
        w_mem_we    = 1'b1;
        w_addr      = r_dst_ptr;
        w_wdata     = r_buf;
        w_state_nxt = (r_remaining == LEN_W'(1)) ? DONE : READ;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Pointers, byte counter and data buffer. Pointers wrap naturally at the
  // address width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_buf       <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_src_ptr   <= bus.src_addr;
            r_dst_ptr   <= bus.dst_addr;
            r_remaining <= bus.length;
`ifdef MEM_COPY_CHECKSUM_EN
            r_csum      <= '0;
`endif
          end
        end
        READ: begin
          r_buf <= bus.mem_read_data;
`ifdef MEM_COPY_CHECKSUM_EN
          r_csum <= r_csum + bus.mem_read_data;
`endif
        end
        WRITE: begin
          r_src_ptr   <= r_src_ptr + 1'b1;
          r_dst_ptr   <= r_dst_ptr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy            = w_busy;
  assign bus.done            = w_done;
  assign bus.mem_read        = w_mem_read;
  assign bus.mem_write_en    = w_mem_we;
  assign bus.mem_access_addr = w_addr;
  assign bus.mem_write_data  = w_wdata;
`ifdef MEM_COPY_CHECKSUM_EN
  assign bus.checksum        = r_csum;
`endif

endmodule
